// File: rtl/gc_poll_sequencer.sv
// gc_poll_sequencer: identifies a GameCube controller, then polls it periodically
// with response timeouts, bounded init retries and a sticky link-lost flag.
module gc_poll_sequencer #(
    parameter int POLL_PERIOD = 100000,
    parameter int RX_TIMEOUT  = 20000,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_init,
    input  logic        poll_enable,
    input  logic        tx_done,
    input  logic        rx_done,
    input  logic        id_ready,
    output logic        tx_start,
    output logic [1:0]  tx_cmd,
    output logic        send,
    output logic        controller_init,
    output logic        poll_valid,
    output logic [15:0] frame_count,
    output logic [7:0]  miss_count,
    output logic        link_lost,
    output logic [2:0]  state
);
    localparam int WW = $clog2(POLL_PERIOD);
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INIT_TX   = 3'd1;
    localparam logic [2:0] S_INIT_RX   = 3'd2;
    localparam logic [2:0] S_POLL_WAIT = 3'd3;
    localparam logic [2:0] S_POLL_TX   = 3'd4;
    localparam logic [2:0] S_POLL_RX   = 3'd5;

    logic [2:0]    r_state, w_next;
    logic [WW-1:0] r_wait;
    logic [TW-1:0] r_to;
    logic [3:0]    r_retry, r_streak;
    logic          r_tx_start, r_send, r_ctrl_init, r_poll_valid, r_link_lost;
    logic [1:0]    r_tx_cmd, w_cmd_next;
    logic [15:0]   r_frame_count;
    logic [7:0]    r_miss_count;
    logic          w_in_rx, w_rx_ok, w_id_ok, w_timeout, w_init_fail, w_poll_fail;
    logic          w_tx_next, w_enter_tx, w_send_next, w_ci_next;

    // start_init pre-empts every other event, so each event is gated by it
    assign w_in_rx     = r_state == S_INIT_RX || r_state == S_POLL_RX;
    assign w_rx_ok     = !start_init && r_state == S_POLL_RX && rx_done;
    assign w_id_ok     = !start_init && r_state == S_INIT_RX && id_ready;
    assign w_timeout   = !start_init && w_in_rx && r_to == TW'(RX_TIMEOUT - 1) && !w_rx_ok && !w_id_ok;
    assign w_init_fail = w_timeout && r_state == S_INIT_RX && r_retry + 1'b1 >= 4'(MAX_RETRY);
    assign w_poll_fail = w_timeout && r_state == S_POLL_RX && r_streak + 1'b1 >= 4'(MAX_RETRY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = S_IDLE;
            S_INIT_TX:   w_next = tx_done ? S_INIT_RX : S_INIT_TX;
            S_INIT_RX:   w_next = w_id_ok ? S_POLL_WAIT : !w_timeout ? S_INIT_RX : w_init_fail ? S_IDLE : S_INIT_TX;
            S_POLL_WAIT: w_next = (r_wait == '0 && poll_enable) ? S_POLL_TX : S_POLL_WAIT;
            S_POLL_TX:   w_next = tx_done ? S_POLL_RX : S_POLL_TX;
            S_POLL_RX:   w_next = w_rx_ok ? S_POLL_WAIT : !w_timeout ? S_POLL_RX : w_poll_fail ? S_IDLE : S_POLL_WAIT;
            default:     w_next = S_IDLE;
        endcase
        if (start_init) w_next = S_INIT_TX;
    end

    // an abort out of a busy state holds send low for the first INIT_TX cycle
    always_comb begin
        w_tx_next   = w_next == S_INIT_TX || w_next == S_POLL_TX;
        w_enter_tx  = start_init || (w_tx_next && w_next != r_state);
        w_send_next = w_tx_next && !(start_init && r_state != S_IDLE);
        w_cmd_next  = w_next == S_INIT_TX ? 2'd1 : w_next == S_POLL_TX ? 2'd0 : r_tx_cmd;
        w_ci_next   = w_next == S_INIT_TX || w_next == S_INIT_RX;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait        <= '0;
            r_to          <= '0;
            r_retry       <= '0;
            r_streak      <= '0;
            r_tx_start    <= 1'b0;
            r_tx_cmd      <= 2'd0;
            r_send        <= 1'b0;
            r_ctrl_init   <= 1'b0;
            r_poll_valid  <= 1'b0;
            r_frame_count <= '0;
            r_miss_count  <= '0;
            r_link_lost   <= 1'b0;
        end else begin
            r_wait        <= (w_next == S_POLL_WAIT && r_state != S_POLL_WAIT) ? WW'(POLL_PERIOD - 1) :
                             (r_state == S_POLL_WAIT && r_wait != '0) ? r_wait - 1'b1 : r_wait;
            r_to          <= (w_next != r_state) ? '0 : w_in_rx ? r_to + 1'b1 : r_to;
            r_retry       <= start_init ? '0 : (r_state == S_INIT_RX && w_timeout) ? r_retry + 1'b1 : r_retry;
            r_streak      <= (w_id_ok || w_rx_ok) ? '0 : (r_state == S_POLL_RX && w_timeout) ? r_streak + 1'b1 : r_streak;
            r_tx_start    <= w_enter_tx;
            r_tx_cmd      <= w_cmd_next;
            r_send        <= w_send_next;
            r_ctrl_init   <= w_ci_next;
            r_poll_valid  <= w_rx_ok;
            r_frame_count <= r_frame_count + 16'(w_rx_ok);
            r_miss_count  <= (r_state == S_POLL_RX && w_timeout && r_miss_count != 8'hFF) ? r_miss_count + 1'b1 : r_miss_count;
            r_link_lost   <= start_init ? 1'b0 : (w_init_fail || w_poll_fail) ? 1'b1 : r_link_lost;
        end
    end

    assign state           = r_state;
    assign tx_start        = r_tx_start;
    assign tx_cmd          = r_tx_cmd;
    assign send            = r_send;
    assign controller_init = r_ctrl_init;
    assign poll_valid      = r_poll_valid;
    assign frame_count     = r_frame_count;
    assign miss_count      = r_miss_count;
    assign link_lost       = r_link_lost;
endmodule

// File: doc/gc_poll_sequencer.md
GC_POLL_SEQUENCER -- requirements
Module: gc_poll_sequencer

Interface
REQ-001 Parameter SHALL be POLL_PERIOD, default 100000, meaning the number of clk cycles spent in POLL_WAIT between polls (minimum 2).
REQ-002 Parameter SHALL be RX_TIMEOUT, default 20000, meaning the number of clk cycles allowed in any RX state before a timeout.
REQ-003 Parameter SHALL be MAX_RETRY, default 3, meaning the number of init attempts and the consecutive poll-miss limit (1..15).
REQ-004 Port SHALL be clk, input, 1 bit: the single clock.
REQ-005 Port SHALL be rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port SHALL be start_init, input, 1 bit: one-cycle request to (re)identify the controller.
REQ-007 Port SHALL be poll_enable, input, 1 bit: level that permits periodic polling.
REQ-008 Port SHALL be tx_done, input, 1 bit: one-cycle pulse from the transmitter when the command has been fully sent.
REQ-009 Port SHALL be rx_done, input, 1 bit: one-cycle pulse from the receiver when a 64-bit response is complete.
REQ-010 Port SHALL be id_ready, input, 1 bit: level from the receiver indicating that the 24-bit wavebird ID has been captured.
REQ-011 Port SHALL be tx_start, output, 1 bit: one-cycle command-start pulse.
REQ-012 Port SHALL be tx_cmd, output, 2 bits: command select, where 0 is POLL and 1 is ID_PROBE.
REQ-013 Port SHALL be send, output, 1 bit: high while a command is on the line.
REQ-014 Port SHALL be controller_init, output, 1 bit: steers the receiver to ID capture.
REQ-015 Port SHALL be poll_valid, output, 1 bit: one-cycle pulse indicating that a new response is valid.
REQ-016 Port SHALL be frame_count, output, 16 bits: count of successful polls.
REQ-017 Port SHALL be miss_count, output, 8 bits: total count of poll timeouts.
REQ-018 Port SHALL be link_lost, output, 1 bit: sticky error flag.
REQ-019 Port SHALL be state, output, 3 bits: encoded FSM state for debug.

Function
REQ-020 The FSM SHALL have the states and encodings IDLE=0, INIT_TX=1, INIT_RX=2, POLL_WAIT=3, POLL_TX=4, POLL_RX=5.
REQ-021 In IDLE, when start_init=1, the FSM SHALL move to INIT_TX next cycle and clear the retry count.
REQ-022 On each entry to INIT_TX or POLL_TX, the block SHALL pulse tx_start for exactly one cycle, in the entry cycle, with tx_cmd 1 or 0 respectively.
REQ-023 send SHALL be 1 from the tx_start cycle through the tx_done cycle inclusive, and 0 otherwise.
REQ-024 In INIT_TX, tx_done SHALL cause a move to INIT_RX; in POLL_TX, tx_done SHALL cause a move to POLL_RX.
REQ-025 controller_init SHALL be 1 exactly while in INIT_TX or INIT_RX.
REQ-026 In INIT_RX, id_ready=1 SHALL cause a move to POLL_WAIT and clear the miss streak.
REQ-027 In INIT_RX, if RX_TIMEOUT cycles elapse without id_ready, the retry count SHALL increment; if the new count is below MAX_RETRY the FSM SHALL go to INIT_TX, otherwise it SHALL set link_lost and go to IDLE.
REQ-028 The wait counter SHALL load POLL_PERIOD-1 on entry to POLL_WAIT and decrement once per cycle, stopping at 0.
REQ-029 In POLL_WAIT, the FSM SHALL move to POLL_TX when the counter is 0 and poll_enable=1; when poll_enable=0 it SHALL hold at 0 and remain in POLL_WAIT.
REQ-030 In POLL_RX, rx_done SHALL pulse poll_valid in the following cycle, increment frame_count (wrapping 0xFFFF to 0x0000), clear the miss streak, and move to POLL_WAIT.
REQ-031 In POLL_RX, a timeout SHALL increment miss_count (saturating at 0xFF) and the miss streak; if the streak is at least MAX_RETRY the block SHALL set link_lost and go to IDLE, otherwise it SHALL go to POLL_WAIT.
REQ-032 The timeout counter SHALL clear on every entry to INIT_RX or POLL_RX, and a timeout SHALL fire in the cycle the counter reaches RX_TIMEOUT-1.
REQ-033 If rx_done or id_ready coincides with the timeout cycle, success SHALL win.
REQ-034 start_init in any non-IDLE state SHALL abort the current operation and move to INIT_TX next cycle, with send dropping in that same next cycle.
REQ-035 start_init SHALL take priority over all other events.
REQ-036 start_init SHALL clear link_lost.
REQ-037 tx_done outside the TX states, and rx_done outside POLL_RX, SHALL be ignored.
REQ-038 Any output that is a function of state SHALL be registered, with no combinational path from input to output.

Reset
REQ-039 While rst=1, state SHALL be IDLE and every output SHALL be 0, including frame_count, miss_count, link_lost, tx_cmd and the internal counters.
REQ-040 Assertion of rst during any state, including mid-transmit, SHALL force send=0 immediately, without waiting for clk.
REQ-041 After rst deasserts, the block SHALL remain in IDLE until start_init.

Verification (POLL_PERIOD=10, RX_TIMEOUT=8, MAX_RETRY=3)
REQ-042 Normal init: start_init, tx_done 5 cycles later, then id_ready -> tx_start with tx_cmd=1, controller_init high through INIT_RX, then state=3.
REQ-043 Periodic poll: poll_enable=1 with tx_done and rx_done each returned promptly -> tx_start with tx_cmd=0 every 10 wait cycles plus the TX/RX time; poll_valid pulses; frame_count=3 after three polls.
REQ-044 Init failure: id_ready never asserted -> 3 tx_start pulses, then link_lost=1 and state=0.
REQ-045 Poll misses: 2 timeouts then an rx_done -> miss_count=2, link_lost=0; 3 consecutive timeouts -> link_lost=1, state=0, miss_count=5.
REQ-046 Boundaries: frame_count preset to 0xFFFF then one poll -> 0x0000; rx_done coincident with the timeout cycle -> poll_valid and no miss.
REQ-047 Abort and reset: start_init during POLL_TX -> INIT_TX with tx_cmd=1 next cycle; rst mid-send -> send=0 asynchronously, all outputs 0.
